// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FSM sequencing fetch/decode/exec/mem/wb (optional SEQ_PERF_CNT_EN stall counter)
module multicycle_sequencer #(
   parameter int CNT_W    = 32,
   parameter int MAX_WAIT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt_req,
   input  logic             mem_ready,
   input  logic             d_mem_read,
   input  logic             d_mem_write,
   input  logic             d_reg_write,
   input  logic             d_branch,
   input  logic             d_jump,
   input  logic             d_is_jal,
   input  logic             d_is_jr,
   input  logic             branch_taken,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_load,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic             rf_we,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] retired,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_ERROR
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [WAIT_W-1:0] wait_cnt;
   logic              waiting;
   logic              timeout;
   logic              retire;
   logic              done_q;

   logic lat_mem_read;
   logic lat_mem_write;
   logic lat_reg_write;
   logic lat_branch;
   logic lat_jump;
   logic lat_is_jal;
   logic lat_is_jr;

   // State register; reset parks the sequencer in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and per-state enables; retire and timeout override the state choice.
   always_comb begin
      state_nx     = state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_load      = 1'b0;
      pc_write     = 1'b0;
      pc_sel       = 2'b00;
      rf_we        = 1'b0;
      retire       = 1'b0;
      waiting      = 1'b0;
      timeout      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_FETCH;
            end
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_load  = 1'b1;
               state_nx = S_DECODE;
            end else begin
               waiting = 1'b1;
            end
         end
         S_DECODE: begin
            state_nx = S_EXEC;
         end
         S_EXEC: begin
            if (lat_jump || lat_is_jr) begin
               pc_write = 1'b1;
               pc_sel   = lat_is_jr ? 2'b11 : 2'b10;
               rf_we    = lat_is_jal;
               retire   = 1'b1;
            end else if (lat_branch) begin
               // A branch with reg_write is the set-on-equal opcode: it writes back instead.
               if (lat_reg_write) begin
                  state_nx = S_WB;
               end else begin
                  pc_write = 1'b1;
                  pc_sel   = {1'b0, branch_taken};
                  retire   = 1'b1;
               end
            end else if (lat_mem_read || lat_mem_write) begin
               state_nx = S_MEM;
            end else begin
               state_nx = S_WB;
            end
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = lat_mem_write;
            if (mem_ready) begin
               if (lat_mem_write) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
               end else begin
                  state_nx = S_WB;
               end
            end else begin
               waiting = 1'b1;
            end
         end
         S_WB: begin
            rf_we    = lat_reg_write;
            pc_write = 1'b1;
            retire   = 1'b1;
         end
         S_ERROR: begin
            state_nx = S_ERROR;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
      if (retire) begin
         state_nx = halt_req ? S_IDLE : S_FETCH;
      end
      timeout = waiting && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
      if (timeout) begin
         state_nx = S_ERROR;
      end
   end

   assign busy = (state != S_IDLE) && (state != S_ERROR);
   assign err  = (state == S_ERROR);
   assign done = done_q;

   // Consecutive wait counter; any non-waiting cycle clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (waiting && !timeout) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   // Decode outputs are captured once per instruction, in DECODE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_mem_read  <= 1'b0;
         lat_mem_write <= 1'b0;
         lat_reg_write <= 1'b0;
         lat_branch    <= 1'b0;
         lat_jump      <= 1'b0;
         lat_is_jal    <= 1'b0;
         lat_is_jr     <= 1'b0;
      end else if (state == S_DECODE) begin
         lat_mem_read  <= d_mem_read;
         lat_mem_write <= d_mem_write;
         lat_reg_write <= d_reg_write;
         lat_branch    <= d_branch;
         lat_jump      <= d_jump;
         lat_is_jal    <= d_is_jal;
         lat_is_jr     <= d_is_jr;
      end
   end

   // Retired-instruction counter and the one-cycle done pulse after a halting retire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= retire && halt_req;
         if (retire) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

`ifdef SEQ_PERF_CNT_EN
   // Counts every cycle a memory request is pending but not yet accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (mem_req && !mem_ready) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - instruction-level model bench for multicycle_sequencer
`timescale 1ns/1ps
module tb_multicycle_sequencer;

   localparam int CNT_W    = 32;
   localparam int MAX_WAIT = 16;

   localparam logic [10:0] M_REQ  = 11'h400;
   localparam logic [10:0] M_WE   = 11'h200;
   localparam logic [10:0] M_ASEL = 11'h100;
   localparam logic [10:0] M_IRL  = 11'h080;
   localparam logic [10:0] M_PCW  = 11'h040;
   localparam logic [10:0] S_BR   = 11'h010;
   localparam logic [10:0] S_J    = 11'h020;
   localparam logic [10:0] S_JR   = 11'h030;
   localparam logic [10:0] M_RFWE = 11'h008;
   localparam logic [10:0] M_BUSY = 11'h004;
   localparam logic [10:0] M_DONE = 11'h002;
   localparam logic [10:0] M_ERR  = 11'h001;

   localparam int C_ALU = 0, C_NOP = 1, C_LW = 2, C_SW = 3, C_BEQ = 4;
   localparam int C_SEQ = 5, C_J = 6, C_JAL = 7, C_JR = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, halt_req, mem_ready;
   logic             d_mem_read, d_mem_write, d_reg_write, d_branch, d_jump, d_is_jal, d_is_jr;
   logic             branch_taken;
   logic             mem_req, mem_we, mem_addr_sel, ir_load, pc_write, rf_we, busy, done, err;
   logic [1:0]       pc_sel;
   logic [CNT_W-1:0] retired, stall_cycles;

   int               checks   = 0;
   int               failures = 0;
   logic             chk_en   = 1'b0;
   logic [10:0]      exp_out  = '0;
   logic [31:0]      exp_retired = '0;
   logic [31:0]      exp_stall   = '0;

   multicycle_sequencer #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .mem_ready(mem_ready),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_reg_write(d_reg_write),
      .d_branch(d_branch), .d_jump(d_jump), .d_is_jal(d_is_jal), .d_is_jr(d_is_jr),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel),
      .rf_we(rf_we), .busy(busy), .done(done), .err(err), .retired(retired),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] dut_vec();
      return {mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_sel, rf_we, busy, done, err};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Compare process: outputs and counters against the model on every checked cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("outputs", {21'd0, dut_vec()}, {21'd0, exp_out});
         chk("retired", retired, exp_retired);
         chk("stall_cycles", stall_cycles, exp_stall);
      end
   end

   task automatic cyc(input logic [10:0] e, input bit ret, input bit stl);
      exp_out = e;
      chk_en  = 1'b1;
      @(posedge clk);
      #1;
      if (ret) exp_retired = exp_retired + 32'd1;
`ifdef SEQ_PERF_CNT_EN
      if (stl) exp_stall = exp_stall + 32'd1;
`else
      if (stl) exp_stall = exp_stall;
`endif
   endtask

   task automatic junk(input bit hold_halt);
      start        = 1'($urandom);
      halt_req     = hold_halt ? 1'b1 : 1'($urandom);
      mem_ready    = 1'($urandom);
      branch_taken = 1'($urandom);
      {d_mem_read, d_mem_write, d_reg_write, d_branch, d_jump, d_is_jal, d_is_jr} = 7'($urandom);
   endtask

   task automatic drive_decode(input int cls);
      {d_mem_read, d_mem_write, d_reg_write, d_branch, d_jump, d_is_jal, d_is_jr} = 7'b0;
      case (cls)
         C_ALU: d_reg_write = 1'b1;
         C_LW:  begin d_mem_read = 1'b1; d_reg_write = 1'b1; end
         C_SW:  d_mem_write = 1'b1;
         C_BEQ: d_branch = 1'b1;
         C_SEQ: begin d_branch = 1'b1; d_reg_write = 1'b1; end
         C_J:   d_jump = 1'b1;
         C_JAL: begin d_jump = 1'b1; d_is_jal = 1'b1; d_reg_write = 1'b1; end
         C_JR:  d_is_jr = 1'b1;
         default: ;
      endcase
   endtask

   // One instruction from FETCH to retire, from its class and the memory wait pattern.
   task automatic do_instr(input int cls, input int fw, input int mw, input bit taken, input bit halt);
      bit is_mem = (cls == C_LW) || (cls == C_SW);
      bit is_wb  = (cls == C_ALU) || (cls == C_NOP) || (cls == C_LW) || (cls == C_SEQ);
      for (int i = 0; i < fw; i++) begin
         junk(1'b0); mem_ready = 1'b0;
         cyc(M_REQ | M_BUSY, 1'b0, 1'b1);
      end
      junk(1'b0); mem_ready = 1'b1;
      cyc(M_REQ | M_IRL | M_BUSY, 1'b0, 1'b0);
      junk(1'b0); drive_decode(cls); start = 1'b1;
      cyc(M_BUSY, 1'b0, 1'b0);
      junk(halt); branch_taken = taken;
      if (cls == C_J || cls == C_JAL || cls == C_JR) begin
         halt_req = halt;
         cyc(M_PCW | M_BUSY | ((cls == C_JR) ? S_JR : S_J) | ((cls == C_JAL) ? M_RFWE : 11'h0), 1'b1, 1'b0);
      end else if (cls == C_BEQ) begin
         halt_req = halt;
         cyc(M_PCW | M_BUSY | (taken ? S_BR : 11'h0), 1'b1, 1'b0);
      end else begin
         cyc(M_BUSY, 1'b0, 1'b0);
      end
      if (is_mem) begin
         for (int i = 0; i < mw; i++) begin
            junk(halt); mem_ready = 1'b0;
            cyc(M_REQ | M_ASEL | M_BUSY | ((cls == C_SW) ? M_WE : 11'h0), 1'b0, 1'b1);
         end
         junk(halt); mem_ready = 1'b1;
         if (cls == C_SW) begin
            halt_req = halt;
            cyc(M_REQ | M_WE | M_ASEL | M_PCW | M_BUSY, 1'b1, 1'b0);
         end else begin
            cyc(M_REQ | M_ASEL | M_BUSY, 1'b0, 1'b0);
         end
      end
      if (is_wb) begin
         junk(halt); halt_req = halt;
         cyc(M_PCW | M_BUSY | ((cls == C_NOP) ? 11'h0 : M_RFWE), 1'b1, 1'b0);
      end
      if (halt) begin
         junk(1'b0); start = 1'b0;
         cyc(M_DONE, 1'b0, 1'b0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
      {d_mem_read, d_mem_write, d_reg_write, d_branch, d_jump, d_is_jal, d_is_jr} = 7'b0;
      @(posedge clk); #1;
      cyc(11'h0, 1'b0, 1'b0);
      cyc(11'h0, 1'b0, 1'b0);
      rst_n = 1'b1;
      cyc(11'h0, 1'b0, 1'b0);
      start = 1'b1;
      cyc(11'h0, 1'b0, 1'b0);

      do_instr(C_ALU, 0, 0, 1'b0, 1'b0);
      chk("pin_retired_after_alu", retired, 32'd1);

      do_instr(C_LW, 0, 3, 1'b0, 1'b0);
      chk("pin_retired_after_lw", retired, 32'd2);
`ifdef SEQ_PERF_CNT_EN
      chk("pin_stall_after_lw", stall_cycles, 32'd3);
`else
      chk("pin_stall_after_lw", stall_cycles, 32'd0);
`endif

      do_instr(C_SW, 0, 0, 1'b0, 1'b0);
      do_instr(C_BEQ, 0, 0, 1'b1, 1'b0);
      chk("pin_retired_after_sw_beq", retired, 32'd4);

      do_instr(C_JAL, 0, 0, 1'b0, 1'b0);
      do_instr(C_JR, 0, 0, 1'b0, 1'b0);
      chk("pin_retired_after_jal_jr", retired, 32'd6);

      do_instr(C_BEQ, 1, 0, 1'b0, 1'b0);
      do_instr(C_SEQ, 0, 0, 1'b1, 1'b0);
      do_instr(C_J, 2, 0, 1'b0, 1'b0);
      do_instr(C_NOP, 0, 0, 1'b0, 1'b0);
      do_instr(C_LW, MAX_WAIT - 1, MAX_WAIT - 1, 1'b0, 1'b0);
      do_instr(C_SW, 1, 2, 1'b0, 1'b0);

      do_instr(C_LW, 0, 1, 1'b0, 1'b1);
      chk("pin_done_cleared", {31'd0, done}, 32'd0);
      cyc(11'h0, 1'b0, 1'b0);
      start = 1'b1;
      cyc(11'h0, 1'b0, 1'b0);
      do_instr(C_ALU, 0, 0, 1'b0, 1'b1);
      chk("pin_retired_after_halts", retired, 32'd14);

      start = 1'b1;
      cyc(11'h0, 1'b0, 1'b0);
      for (int i = 0; i < MAX_WAIT; i++) begin
         junk(1'b0); mem_ready = 1'b0;
         cyc(M_REQ | M_BUSY, 1'b0, 1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         junk(1'b0); start = 1'b1;
         cyc(M_ERR, 1'b0, 1'b0);
      end
      chk("pin_err_sticky", {31'd0, err}, 32'd1);

      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("pin_async_reset_outputs", {21'd0, dut_vec()}, 32'd0);
      chk("pin_async_reset_retired", retired, 32'd0);
      chk("pin_async_reset_stall", stall_cycles, 32'd0);
      exp_retired = '0;
      exp_stall   = '0;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(11'h0, 1'b0, 1'b0);
      start = 1'b1;
      cyc(11'h0, 1'b0, 1'b0);
      do_instr(C_BEQ, 0, 0, 1'b1, 1'b1);
      chk("pin_retired_after_recovery", retired, 32'd1);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM sequencing the MIPS-style datapath around the combinational control unit.
- Shares one memory port between instruction fetch and load/store.
- Latches the control unit's decode outputs once per instruction, then issues per-state enables for PC, IR, memory and register file.
- Sits between the control unit, the PC/IR registers and the single-port memory wrapper.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (and the stall counter when enabled).
- MAX_WAIT, 16, consecutive mem_ready-low cycles with mem_req high that cause the error state. Must be ≥1.

Ports:
- clk input 1: rising-edge clock.
- rst_n input 1: asynchronous active-low reset.
- start input 1: begin execution from IDLE.
- halt_req input 1: stop after the current instruction retires.
- mem_ready input 1: memory completes the current request this cycle.
- d_mem_read, d_mem_write, d_reg_write, d_branch, d_jump, d_is_jal, d_is_jr input 1 each: control unit decode outputs.
- branch_taken input 1: datapath comparison result for the latched branch type.
- mem_req output 1: memory access request.
- mem_we output 1: write strobe, valid with mem_req.
- mem_addr_sel output 1: 0 = PC, 1 = ALU result.
- ir_load output 1: load IR from memory read data.
- pc_write output 1: update PC.
- pc_sel output 2: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs (jr).
- rf_we output 1: register file write enable.
- busy output 1: high in every state except IDLE and ERROR.
- done output 1: one-cycle pulse on halt.
- err output 1: sticky memory-timeout flag.
- retired output CNT_W: retired-instruction count.
- stall_cycles output CNT_W: memory wait cycles (see Optional Feature).

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR.
- Outputs are Moore-decoded from state and latched controls, except ir_load, the MEM retire and the timeout, which also use mem_ready.
- Reset (async, any state): state=IDLE, all latched controls cleared, retired=0, stall_cycles=0, wait counter=0, err=0. Consequently every output is 0.
- IDLE: start=1 → FETCH. start in any other state is ignored.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - mem_ready=1 → ir_load=1 in the same cycle, → DECODE.
  - Otherwise hold FETCH and increment the wait counter.
- DECODE: latch all d_* inputs; → EXEC. Decode inputs are sampled only here.
- EXEC, by latched controls, in priority order:
  - jump or is_jr: pc_write=1, pc_sel = is_jr ? 11 : 10. rf_we=1 if is_jal (link write). Retire.
  - branch: pc_write=1, pc_sel = branch_taken ? 01 : 00. rf_we=0 except when reg_write is set on the custom opcode (seq) → WB instead, with no pc_write in EXEC. Retire on the branch path.
  - mem_read or mem_write → MEM.
  - Otherwise → WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=latched mem_write.
  - On mem_ready: load → WB; store → pc_write=1, pc_sel=00, retire.
  - Waits count like FETCH waits.
- WB: rf_we=latched reg_write, pc_write=1, pc_sel=00, retire.
- Retire (same cycle as the final enables):
  - retired += 1, wrapping modulo 2^CNT_W.
  - halt_req=1 → IDLE with done=1 for one cycle; else → FETCH.
  - halt_req is sampled only at retire.
- Wait counter:
  - Cleared on every mem_ready=1 and on leaving FETCH/MEM.
  - Reaching MAX_WAIT while still waiting → ERROR in the next cycle.
- ERROR: err=1, every enable 0, busy=0. Exit only via rst_n.
- One memory request is outstanding at a time. mem_req stays asserted until the mem_ready cycle, with no gap between.
- CPI with zero wait states: ALU = 4, load = 5, store = 4, jump/branch = 3.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- When defined: stall_cycles increments (wrapping) every cycle with mem_req=1 and mem_ready=0; reset to 0 by rst_n.
- When undefined: the counter logic is omitted and stall_cycles is tied to 0. The port list is unchanged.

Test Plan:
- Reset, start=1, mem_ready always 1, ALU op (d_reg_write=1) → enable sequence FETCH ir_load, DECODE, EXEC, WB rf_we=1 + pc_write pc_sel=00; retired=1 after 4 cycles.
- lw with mem_ready low for 3 cycles in MEM → mem_req held 4 cycles, mem_addr_sel=1, mem_we=0, rf_we in WB; with SEQ_PERF_CNT_EN stall_cycles=3, without it stall_cycles=0.
- sw followed by beq with branch_taken=1 → store retires from MEM with mem_we=1, pc_sel=00; beq EXEC gives pc_write=1, pc_sel=01; retired=2.
- jal then jr → EXEC pc_sel=10 with rf_we=1; then pc_sel=11 with rf_we=0.
- halt_req=1 raised mid-instruction → current instruction completes, done pulses 1 cycle, busy=0, start ignored while busy.
- mem_ready held 0 in FETCH with MAX_WAIT=16 → ERROR after 16 wait cycles, err=1 and all enables 0; rst_n low mid-ERROR clears err, retired=0, state IDLE.
